// File: rtl/exposure_timer.sv
// Exposure countdown with button-adjustable setting; Start to Ovf5 takes Exp_time*TICK_DIV cycles.
// No backpressure: Start is ignored while busy, and button presses are dropped (not queued) when not idle.
module exposure_timer #(
  parameter int TICK_DIV  = 4,
  parameter int EXP_MIN   = 2,
  parameter int EXP_MAX   = 30,
  parameter int EXP_RESET = 2
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Init,
  input  logic       Start,
  input  logic       Exp_increase,
  input  logic       Exp_decrease,
  output logic       Ovf5,
  output logic       Busy,
  output logic [4:0] Exp_time
);

  localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);
  localparam logic [4:0] EXP_MIN_V  = 5'(EXP_MIN);
  localparam logic [4:0] EXP_MAX_V  = 5'(EXP_MAX);
  localparam logic [4:0] EXP_RST_V  = 5'(EXP_RESET);

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [4:0] unit_q;
  logic [7:0] presc_q;
  logic       inc_prev_q, dec_prev_q;
  logic       start_acc, tick, last_tick;
  logic       inc_press, dec_press, press_ok;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (Init) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (Start)     state_d = COUNT;
        COUNT:   if (last_tick) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    Busy      = (state_q == COUNT);
    start_acc = (state_q == IDLE) && Start && !Init;
    tick      = (state_q == COUNT) && (presc_q == PRESC_LAST);
    last_tick = tick && (unit_q == 5'd1);
    inc_press = Exp_increase && !inc_prev_q;
    dec_press = Exp_decrease && !dec_prev_q;
    // An accepted Start also suppresses presses on that edge.
    press_ok  = (state_q == IDLE) && !Init && !Start;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      unit_q     <= 5'd0;
      presc_q    <= 8'd0;
      Ovf5       <= 1'b0;
      Exp_time   <= EXP_RST_V;
      inc_prev_q <= 1'b0;
      dec_prev_q <= 1'b0;
    end else begin
      inc_prev_q <= Exp_increase;
      dec_prev_q <= Exp_decrease;
      Ovf5       <= 1'b0;
      if (Init) begin
        unit_q  <= 5'd0;
        presc_q <= 8'd0;
      end else if (start_acc) begin
        unit_q  <= Exp_time;
        presc_q <= 8'd0;
      end else if (state_q == COUNT) begin
        if (tick) begin
          presc_q <= 8'd0;
          unit_q  <= unit_q - 5'd1;
          Ovf5    <= last_tick;
        end else begin
          presc_q <= presc_q + 8'd1;
        end
      end
      // Simultaneous presses cancel each other out.
      if (press_ok && (inc_press != dec_press)) begin
        if (inc_press && (Exp_time < EXP_MAX_V))
          Exp_time <= Exp_time + 5'd1;
        else if (dec_press && (Exp_time > EXP_MIN_V))
          Exp_time <= Exp_time - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_exposure_timer.sv
// Bench for exposure_timer: timestamp-based reference model checked every cycle, plus directed literal checks.
module tb_exposure_timer;
  localparam int TD = 4, EMIN = 2, EMAX = 30, ERST = 2;

  logic clk = 1'b0, Reset = 1'b0, Init = 1'b0, Start = 1'b0;
  logic Exp_increase = 1'b0, Exp_decrease = 1'b0;
  logic Ovf5, Busy;
  logic [4:0] Exp_time;
  int checks = 0, failures = 0;

  exposure_timer #(.TICK_DIV(TD), .EXP_MIN(EMIN), .EXP_MAX(EMAX), .EXP_RESET(ERST)) dut (
    .clk(clk), .Reset(Reset), .Init(Init), .Start(Start),
    .Exp_increase(Exp_increase), .Exp_decrease(Exp_decrease),
    .Ovf5(Ovf5), .Busy(Busy), .Exp_time(Exp_time)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an exposure is a start timestamp plus a length in cycles.
  int n = 0, m_exp = ERST, m_st = 0, m_len = 0;
  bit m_busy = 0, m_ovf = 0, m_act = 0, h_inc = 0, h_dec = 0;
  bit pb, ip, dp;

  always @(negedge Reset) begin
    m_busy = 0; m_ovf = 0; m_act = 0; m_exp = ERST; h_inc = 0; h_dec = 0;
  end

  always @(posedge clk) begin
    n++;
    if (Reset) begin
      pb = m_busy;
      ip = Exp_increase && !h_inc;
      dp = Exp_decrease && !h_dec;
      h_inc = Exp_increase;
      h_dec = Exp_decrease;
      m_ovf = 0;
      if (Init) begin
        m_act = 0;
      end else if (!pb && Start) begin
        m_act = 1; m_st = n; m_len = m_exp * TD;
      end else begin
        if (m_act && (n - m_st == m_len)) begin
          m_act = 0; m_ovf = 1;
        end
        if (!pb && (ip != dp)) begin
          if (ip) m_exp = (m_exp + 1 > EMAX) ? EMAX : m_exp + 1;
          else    m_exp = (m_exp - 1 < EMIN) ? EMIN : m_exp - 1;
        end
      end
      m_busy = m_act;
    end
  end

  always @(negedge clk) begin
    if (Reset) begin
      chk("model_busy", int'(Busy), int'(m_busy));
      chk("model_ovf5", int'(Ovf5), int'(m_ovf));
      chk("model_exp_time", int'(Exp_time), m_exp);
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input bit inc, input bit dec);
    Exp_increase = inc; Exp_decrease = dec;
    cyc(1);
    Exp_increase = 0; Exp_decrease = 0;
    cyc(1);
  endtask

  // Called just after the accepting edge; counts edges during which Busy stays high.
  task automatic busy_len(output int len, input bit press_inc);
    len = 0;
    while (Busy && len < 200) begin
      len++;
      Exp_increase = press_inc && (len >= 2) && (len < 4);
      cyc(1);
    end
    Exp_increase = 0;
  endtask

  task automatic wait_ovf(output int t);
    t = -1000;
    for (int i = 0; i < 200; i++) begin
      cyc(1);
      if (Ovf5) begin
        t = n;
        break;
      end
    end
  endtask

  int len, t0, t1, t2, ovf_cnt;

  initial begin
    #12;
    chk("reset_busy", int'(Busy), 0);
    chk("reset_ovf5", int'(Ovf5), 0);
    chk("reset_exp_time", int'(Exp_time), 2);
    @(posedge clk); #2;
    Reset = 1;

    // Default exposure: 2 units * 4 cycles.
    Start = 1; cyc(1); Start = 0;
    busy_len(len, 0);
    chk("default_busy_len", len, 8);
    chk("default_ovf5_high", int'(Ovf5), 1);
    chk("default_busy_at_ovf", int'(Busy), 0);
    cyc(1);
    chk("default_ovf5_one_cycle", int'(Ovf5), 0);

    // Saturating setting adjustment.
    press(1, 0);
    chk("inc_first_step", int'(Exp_time), 3);
    repeat (30) press(1, 0);
    chk("inc_saturate", int'(Exp_time), 30);
    repeat (40) press(0, 1);
    chk("dec_saturate", int'(Exp_time), 2);
    press(1, 0); press(1, 0);
    chk("inc_to_4", int'(Exp_time), 4);
    press(1, 1);
    chk("both_pressed", int'(Exp_time), 4);
    press(1, 0);
    chk("inc_to_5", int'(Exp_time), 5);

    // Start held high: restart every 5*4+1 cycles.
    Start = 1;
    wait_ovf(t0); wait_ovf(t1); wait_ovf(t2);
    chk("held_period_1", t1 - t0, 21);
    chk("held_period_2", t2 - t1, 21);
    Start = 0;
    cyc(3);

    // Press during countdown is dropped.
    Start = 1; cyc(1); Start = 0;
    busy_len(len, 1);
    chk("press_in_count_len", len, 20);
    chk("press_in_count_exp", int'(Exp_time), 5);
    chk("press_in_count_ovf5", int'(Ovf5), 1);
    cyc(2);

    // Init three cycles after Start aborts.
    Start = 1; cyc(1); Start = 0;
    cyc(2);
    Init = 1; cyc(1); Init = 0;
    chk("init_abort_busy", int'(Busy), 0);
    ovf_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (Ovf5) ovf_cnt++;
    end
    chk("init_abort_no_ovf5", ovf_cnt, 0);

    // Init on the final tick wins over Ovf5.
    Start = 1; cyc(1); Start = 0;
    cyc(19);
    Init = 1; cyc(1); Init = 0;
    chk("init_final_ovf5", int'(Ovf5), 0);
    chk("init_final_busy", int'(Busy), 0);
    cyc(2);

    // Asynchronous reset mid-count.
    Start = 1; cyc(1); Start = 0;
    cyc(5);
    #1 Reset = 0;
    #1;
    chk("async_reset_busy", int'(Busy), 0);
    chk("async_reset_ovf5", int'(Ovf5), 0);
    chk("async_reset_exp_time", int'(Exp_time), 2);
    cyc(1);
    Reset = 1;

    // First edge after release accepts Start.
    Start = 1; cyc(1); Start = 0;
    chk("post_reset_start", int'(Busy), 1);
    busy_len(len, 0);
    chk("post_reset_len", len, 8);
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exposure_timer.md
EXPOSURE_TIMER -- requirements
Module: exposure_timer

Interface
REQ-001 Parameter TICK_DIV, default 4: clk cycles per exposure time unit (range 1..255).
REQ-002 Parameter EXP_MIN, default 2: minimum exposure setting in units.
REQ-003 Parameter EXP_MAX, default 30: maximum exposure setting in units.
REQ-004 Parameter EXP_RESET, default 2: exposure setting after reset, with EXP_MIN <= EXP_RESET <= EXP_MAX.
REQ-005 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 Reset  input  1  asynchronous active-low reset.
REQ-008 Init  input  1  synchronous abort/restart request from the exposure control FSM.
REQ-009 Start  input  1  begin-exposure request from the exposure control FSM; sampled on a level basis.
REQ-010 Exp_increase  input  1  user button; a rising edge raises the exposure setting.
REQ-011 Exp_decrease  input  1  user button; a rising edge lowers the exposure setting.
REQ-012 Ovf5  output  1  one-cycle pulse marking the end of the exposure; consumed by the exposure control FSM.
REQ-013 Busy  output  1  high while an exposure countdown is running.
REQ-014 Exp_time  output  5  current exposure setting in units.

Function
REQ-015 Button edge detection: register each button once per cycle; a press is detected when the current sample is 1 and the previous sample is 0.
REQ-016 A detected increase press SHALL set Exp_time to min(Exp_time+1, EXP_MAX), saturating with no wrap.
REQ-017 A detected decrease press SHALL set Exp_time to max(Exp_time-1, EXP_MIN), saturating with no wrap.
REQ-018 Increase and decrease presses detected on the same edge SHALL both be ignored.
REQ-019 Presses SHALL be applied only when Busy=0 and no Start is accepted on that edge; otherwise they are dropped, not queued.
REQ-020 The state machine has two states: IDLE and COUNT.
REQ-021 IDLE -> COUNT: on an edge with Start=1 and Init=0, load the unit counter with Exp_time and clear the prescaler to 0.
REQ-022 In COUNT, the prescaler increments every cycle; on reaching TICK_DIV-1 it wraps to 0 and the unit counter decrements.
REQ-023 COUNT -> IDLE: on the tick that decrements the unit counter from 1 to 0, Ovf5 is registered high for exactly one cycle.
REQ-024 Latency: if Start is accepted at edge k, Busy SHALL be 1 after edges k .. k+Exp_time*TICK_DIV-1, and Busy=0 and Ovf5=1 after edge k+Exp_time*TICK_DIV.
REQ-025 Exp_time SHALL be latched at Start acceptance; the countdown SHALL use that latched value.
REQ-026 Start asserted while in COUNT SHALL be ignored; a level held high across the Ovf5 edge SHALL not retrigger on that same edge.
REQ-027 Start still high in IDLE on the cycle after Ovf5 SHALL start a new exposure.
REQ-028 Init=1 on any edge SHALL force IDLE, clear the counter, prescaler and Ovf5, and block Start on that edge; Exp_time is unchanged.
REQ-029 When Init and Ovf5 would coincide, Init wins and no Ovf5 pulse is produced.

Reset
REQ-030 Reset=0 SHALL immediately force IDLE, Ovf5=0, Busy=0, counter and prescaler = 0, Exp_time=EXP_RESET, and button history = 0, regardless of clk.
REQ-031 Reset deasserted mid-exposure SHALL leave the block in IDLE with no Ovf5 pulse.
REQ-032 The first edge after reset release SHALL accept Start normally.

Verification
REQ-033 Defaults, Start pulsed for 1 cycle -> Busy high for 8 cycles, then Ovf5=1 for exactly 1 cycle with Busy=0 on the same cycle.
REQ-034 31 increase presses from reset -> Exp_time steps 2..30 and holds at 30; 40 decrease presses -> Exp_time holds at 2; both buttons pressed together -> Exp_time unchanged.
REQ-035 Exp_time=5 and TICK_DIV=4, Start held high continuously -> Ovf5 pulses every 21 cycles (20 cycles counting + 1 idle restart).
REQ-036 Increase pressed during COUNT -> Exp_time unchanged and the countdown length unchanged.
REQ-037 Init asserted 3 cycles after Start -> Busy=0 on the next cycle, and no Ovf5 occurs within 100 cycles.
REQ-038 Reset pulled low mid-count at a non-edge time -> Busy=0 and Ovf5=0 immediately, Exp_time=2.
